// File: rtl/gpr_file_mp_if.sv
// Register-file access bus: read ports, writeback port and issue scoreboard port.
// Every signal is a plain level for the current cycle; there is no valid/ready
// handshake. we and iss_valid qualify their address/data fields in the same cycle.
interface gpr_file_mp_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
);
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic [NRD-1:0]    rpend;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DW/8-1:0]   wbe;
    logic [DW-1:0]     wdata;
    logic              iss_valid;
    logic [AW-1:0]     iss_reg;

    // Decode/writeback side drives addresses, data and issue information.
    modport master (
        output raddr, we, waddr, wbe, wdata, iss_valid, iss_reg,
        input  rdata, rpend
    );

    // Register file side answers reads and pending status.
    modport slave (
        input  raddr, we, waddr, wbe, wdata, iss_valid, iss_reg,
        output rdata, rpend
    );
endinterface

// File: rtl/gpr_file_mp.sv
// MIPS general-purpose register file: NRD combinational read ports, one
// byte-enabled write port, optional write-to-read bypass and a per-register
// pending-write scoreboard feeding the hazard unit.
module gpr_file_mp #(
    parameter int          DW      = 32,
    parameter int          AW      = 5,
    parameter int          NRD     = 2,
    parameter bit          BYPASS  = 1'b1,
    parameter int          GP_IDX  = 28,
    parameter logic [DW-1:0] GP_INIT = 32'h0000_1800,
    parameter int          SP_IDX  = 29,
    parameter logic [DW-1:0] SP_INIT = 32'h0000_2ffc
) (
    input logic         clk,
    input logic         rst,
    gpr_file_mp_if.slave bus
);
    localparam int DEPTH = 2 ** AW;
    localparam int NB    = DW / 8;

    logic [DW-1:0]    regs_q [DEPTH];
    logic [DW-1:0]    regs_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // Byte b comes from new_v when be[b] is set, otherwise from old_v.
    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    logic wr_act;
    logic iss_act;
    assign wr_act  = bus.we && (bus.waddr != '0);
    assign iss_act = bus.iss_valid && (bus.iss_reg != '0);

    // Next-state of registers and scoreboard; a set of pend wins over a clear
    // because the issuing instruction is a newer producer than the writeback.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_act) begin
            regs_d[bus.waddr] = merge(regs_q[bus.waddr], bus.wdata, bus.wbe);
            pend_d[bus.waddr] = 1'b0;
        end
        if (iss_act) begin
            pend_d[bus.iss_reg] = 1'b1;
        end
    end

    // State update; reset discards any write or issue presented the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (r == GP_IDX)      regs_q[r] <= GP_INIT;
                else if (r == SP_IDX) regs_q[r] <= SP_INIT;
                else                  regs_q[r] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    // Combinational read ports with optional forwarding of the in-flight write.
    always_comb begin
        logic [AW-1:0] a;
        logic          hit;
        a          = '0;
        hit        = 1'b0;
        bus.rdata  = '0;
        bus.rpend  = '0;
        for (int i = 0; i < NRD; i++) begin
            a   = bus.raddr[i*AW +: AW];
            hit = BYPASS && bus.we && (bus.waddr == a);
            if (a == '0) begin
                bus.rdata[i*DW +: DW] = '0;
                bus.rpend[i]          = 1'b0;
            end else begin
                if (hit) bus.rdata[i*DW +: DW] = merge(regs_q[a], bus.wdata, bus.wbe);
                else     bus.rdata[i*DW +: DW] = regs_q[a];
                bus.rpend[i] = pend_q[a] && !hit;
            end
        end
    end
endmodule
